hex_frame_collector: RTL
========================

Name: hex_frame_collector

Overview:
- Parametrised successor to the fixed 6-nibble UART hex collector.
- Accumulates hex digits decoded from the UART receive path into an N-nibble frame.
- Commits the frame on a terminator character and keeps a history copy of the previous committed frame.
- Adds configurable digit order, overflow policy, abort/error handling and per-frame status pulses. Sits between the ASCII classifier (after uart_rx) and the display/compare logic.

Parameters:
- NIBBLES, 6: maximum digits per frame; data width W = 4*NIBBLES; legal range 1..16.
- MSB_FIRST, 1: 1 = typed order (each new digit shifts acc left and enters at [3:0]); 0 = positional (digit k written to nibble k, LSB first).
- OVF_WRAP, 0: 0 = digits beyond NIBBLES are dropped and overflow is flagged; 1 = excess digits are kept as the most recent NIBBLES (only honoured when MSB_FIRST=1, otherwise behaves as 0).

Ports:
- clk_60mhz  in  1  system clock, 60 MHz
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe; one classified character
- rx_class  in  2  0 = other/invalid, 1 = hex digit, 2 = terminator, 3 = abort; sampled only with rx_valid
- rx_nibble  in  4  digit value; sampled only when rx_valid and rx_class=1
- value_current  out  W  last committed frame
- value_before  out  W  frame committed before value_current
- digit_count  out  $clog2(NIBBLES+1)  digits accepted in the open frame, saturates at NIBBLES
- frame_done  out  1  one-cycle pulse on commit
- frame_ovf  out  1  valid with frame_done; committed frame had excess digits
- frame_err  out  1  one-cycle pulse when an errored frame is discarded at its terminator
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): all outputs 0, acc 0, ovf_flag 0, state IDLE.
- Inputs are ignored when rx_valid=0; no state change occurs.
- All outputs are registered. The effect of an rx_valid appears the next rising edge.
- FSM states: IDLE, COLLECT, FULL, ERROR.
- IDLE:
  - hex: acc is loaded with that digit only; count=1; go to COLLECT, or FULL if NIBBLES=1.
  - terminator or abort: ignored; no pulse.
  - other: go to ERROR.
- COLLECT:
  - hex: insert the digit per MSB_FIRST; count+1; go to FULL when count reaches NIBBLES.
  - terminator: commit.
  - abort: clear acc and count; go to IDLE; no pulse.
  - other: go to ERROR.
- FULL:
  - hex with OVF_WRAP=0: digit dropped; ovf_flag=1.
  - hex with OVF_WRAP=1: acc = {acc[W-5:0], digit}; ovf_flag=1.
  - terminator: commit.
  - abort or other: same as COLLECT.
- ERROR:
  - hex and other: discarded.
  - terminator: frame_err=1 for one cycle; no commit; acc and count cleared; go to IDLE.
  - abort: go to IDLE silently.
- Commit, all in one edge:
  - value_before <= value_current and value_current <= acc.
  - frame_done=1 and frame_ovf=ovf_flag.
  - acc, count and ovf_flag cleared; go to IDLE.
- Positional mode: unwritten nibbles in the committed frame are 0.
- Back-to-back rx_valid on consecutive cycles must be handled with no lost character.
- Pulses last exactly one cycle. frame_ovf is 0 when frame_done is 0.
- Reset mid-frame: the partial frame is lost and both history registers are zeroed.

Decomposition:
- Shared package hex_uart_pkg:
  - rx_class constants CLS_OTHER/CLS_HEX/CLS_TERM/CLS_ABORT.
  - FSM state encoding.
  - Terminator (CR, 0x0D) and abort (ESC, 0x1B) ASCII codes for the upstream classifier.
- One natural sub-module: hex_nibble_accum.
  - Holds acc and count; implements MSB/positional insert and the wrap shift.
  - Controlled by load/insert/clear strobes from the FSM.
  - History registers and pulses stay in the top level.

Test Plan:
- NIBBLES=6, MSB_FIRST=1; digits 1,2,3 then term -> value_current=0x000123, frame_done one cycle, frame_ovf=0, value_before=0.
- MSB_FIRST=0; digits 1,2,3, term -> 0x000321. Then A,B, term -> value_current=0x0000BA, value_before=0x000321.
- OVF_WRAP=0; digits 1..7, term -> 0x123456, frame_ovf=1. Repeat with OVF_WRAP=1 -> 0x234567, frame_ovf=1.
- Digits 5,5, class other, digit 9, term -> frame_err pulse; value_current unchanged. Next frame 7, term -> 0x000007.
- Lone term in IDLE -> no pulse. Digits 4,4, abort, term -> no pulse; count=0; outputs unchanged.
- Digits 1,2 on consecutive cycles, then assert rst before term -> all outputs 0 immediately. After release, digit 8, term -> 0x000008.

Source files
------------

// File: rtl/hex_uart_pkg.sv
// Shared definitions for the UART hex-frame path.
//   - rx_class codes produced by the ASCII classifier behind uart_rx
//   - frame collector FSM state encoding
//   - ASCII codes the upstream classifier maps to CLS_TERM / CLS_ABORT
package hex_uart_pkg;

  // Character class codes carried on rx_class
  localparam logic [1:0] CLS_OTHER = 2'd0;
  localparam logic [1:0] CLS_HEX   = 2'd1;
  localparam logic [1:0] CLS_TERM  = 2'd2;
  localparam logic [1:0] CLS_ABORT = 2'd3;

  // Collector FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  // Characters the classifier turns into terminator / abort
  localparam logic [7:0] ASCII_TERM  = 8'h0D;  // CR
  localparam logic [7:0] ASCII_ABORT = 8'h1B;  // ESC

endpackage

// File: rtl/hex_frame_collector_if.sv
// Bus between the ASCII classifier and the hex frame collector.
//   master : classifier/test side, drives rx_valid/rx_class/rx_nibble,
//            observes the frame outputs
//   slave  : collector side
// Signals:
//   rx_valid, rx_class[1:0], rx_nibble[3:0]           classified character
//   value_current[W-1:0], value_before[W-1:0]         committed frames
//   digit_count[CW-1:0]                               digits in open frame
//   frame_done, frame_ovf, frame_err, busy            status
interface hex_frame_collector_if #(
  parameter int NIBBLES = 6
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  logic          rx_valid;
  logic [1:0]    rx_class;
  logic [3:0]    rx_nibble;
  logic [W-1:0]  value_current;
  logic [W-1:0]  value_before;
  logic [CW-1:0] digit_count;
  logic          frame_done;
  logic          frame_ovf;
  logic          frame_err;
  logic          busy;

  modport master (
    output rx_valid, rx_class, rx_nibble,
    input  value_current, value_before, digit_count,
           frame_done, frame_ovf, frame_err, busy
  );

  modport slave (
    input  rx_valid, rx_class, rx_nibble,
    output value_current, value_before, digit_count,
           frame_done, frame_ovf, frame_err, busy
  );
endinterface

// File: rtl/hex_nibble_accum.sv
// Nibble accumulator for the hex frame collector.
// Holds the open frame (acc) and its digit count; the FSM steers it with
// one-hot-ish strobes (clear has priority, then load, insert, shift).
// Ports:
//   clk_60mhz, rst      clock, async active-high reset
//   load                start a new frame with nibble, count = 1
//   insert              add nibble (typed or positional order), count + 1
//   shift               wrap-mode overflow: shift nibble in, count unchanged
//   clear               empty the frame
//   nibble[3:0]         digit value
//   acc[W-1:0]          accumulated frame
//   count[CW-1:0]       digits accepted
module hex_nibble_accum #(
  parameter int NIBBLES   = 6,
  parameter int MSB_FIRST = 1
) (
  input  logic                             clk_60mhz,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             insert,
  input  logic                             shift,
  input  logic                             clear,
  input  logic [3:0]                       nibble,
  output logic [4*NIBBLES-1:0]             acc,
  output logic [$clog2(NIBBLES+1)-1:0]     count
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  logic [W-1:0]  acc_r;
  logic [W-1:0]  acc_next_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // Typed-order insert: older digits move up one nibble, new one enters at [3:0]
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] a, input logic [3:0] n);
    return (a << 3'd4) | W'(n);
  endfunction

  // Next-state of the frame and its digit count
  always_comb begin
    acc_next_s   = acc_r;
    count_next_s = count_r;
    if (clear) begin
      acc_next_s   = '0;
      count_next_s = '0;
    end else if (load) begin
      acc_next_s   = W'(nibble);
      count_next_s = CW'(1);
    end else if (insert) begin
      if (MSB_FIRST != 0) begin
        acc_next_s = shift_in(acc_r, nibble);
      end else begin
        // Positional: digit number count lands in nibble slot count
        for (int k = 0; k < NIBBLES; k++) begin
          if (count_r == CW'(k)) begin
            acc_next_s[4*k +: 4] = nibble;
          end else begin
            acc_next_s[4*k +: 4] = acc_next_s[4*k +: 4];
          end
        end
      end
      count_next_s = count_r + CW'(1);
    end else if (shift) begin
      acc_next_s = shift_in(acc_r, nibble);
    end else begin
      acc_next_s   = acc_r;
      count_next_s = count_r;
    end
  end

  // Frame and count registers
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      acc_r   <= '0;
      count_r <= '0;
    end else begin
      acc_r   <= acc_next_s;
      count_r <= count_next_s;
    end
  end

  assign acc   = acc_r;
  assign count = count_r;
endmodule

// File: rtl/hex_frame_collector.sv
// Hex frame collector: builds an N-nibble frame from classified UART
// characters, commits it on a terminator and keeps the previous frame.
// Ports:
//   clk_60mhz   60 MHz system clock
//   rst         asynchronous active-high reset
//   bus         hex_frame_collector_if.slave (rx character in, frame status out)
// Parameters:
//   NIBBLES     frame size in digits (1..16)
//   MSB_FIRST   1 = typed order, 0 = positional (LSB first)
//   OVF_WRAP    1 = keep the most recent NIBBLES digits on overflow (typed order only)
module hex_frame_collector
  import hex_uart_pkg::*;
#(
  parameter int NIBBLES   = 6,
  parameter int MSB_FIRST = 1,
  parameter int OVF_WRAP  = 0
) (
  input  logic                  clk_60mhz,
  input  logic                  rst,
  hex_frame_collector_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  // Wrapping is meaningless in positional order, so it is only enabled for typed order
  localparam bit WRAP_EN = (OVF_WRAP != 0) && (MSB_FIRST != 0);

  state_t        state_r;
  state_t        state_next_s;
  logic [W-1:0]  acc_s;
  logic [CW-1:0] count_s;
  logic          acc_load_s;
  logic          acc_insert_s;
  logic          acc_shift_s;
  logic          acc_clear_s;
  logic          commit_s;
  logic          err_s;
  logic          set_ovf_s;
  logic          ovf_flag_r;
  logic [W-1:0]  value_current_r;
  logic [W-1:0]  value_before_r;
  logic          frame_done_r;
  logic          frame_ovf_r;
  logic          frame_err_r;

  hex_nibble_accum #(
    .NIBBLES   (NIBBLES),
    .MSB_FIRST (MSB_FIRST)
  ) u_accum (
    .clk_60mhz (clk_60mhz),
    .rst       (rst),
    .load      (acc_load_s),
    .insert    (acc_insert_s),
    .shift     (acc_shift_s),
    .clear     (acc_clear_s),
    .nibble    (bus.rx_nibble),
    .acc       (acc_s),
    .count     (count_s)
  );

  // FSM next-state and accumulator/pulse strobes
  always_comb begin
    state_next_s = state_r;
    acc_load_s   = 1'b0;
    acc_insert_s = 1'b0;
    acc_shift_s  = 1'b0;
    acc_clear_s  = 1'b0;
    commit_s     = 1'b0;
    err_s        = 1'b0;
    set_ovf_s    = 1'b0;
    if (bus.rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          case (bus.rx_class)
            CLS_HEX: begin
              acc_load_s   = 1'b1;
              state_next_s = (NIBBLES == 1) ? ST_FULL : ST_COLLECT;
            end
            CLS_OTHER: state_next_s = ST_ERROR;
            default:   state_next_s = ST_IDLE;  // stray terminator/abort
          endcase
        end
        ST_COLLECT: begin
          case (bus.rx_class)
            CLS_HEX: begin
              acc_insert_s = 1'b1;
              if (count_s == CW'(NIBBLES - 1)) begin
                state_next_s = ST_FULL;
              end else begin
                state_next_s = ST_COLLECT;
              end
            end
            CLS_TERM: begin
              commit_s     = 1'b1;
              acc_clear_s  = 1'b1;
              state_next_s = ST_IDLE;
            end
            CLS_ABORT: begin
              acc_clear_s  = 1'b1;
              state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_ERROR;
          endcase
        end
        ST_FULL: begin
          case (bus.rx_class)
            CLS_HEX: begin
              set_ovf_s   = 1'b1;
              acc_shift_s = WRAP_EN;
            end
            CLS_TERM: begin
              commit_s     = 1'b1;
              acc_clear_s  = 1'b1;
              state_next_s = ST_IDLE;
            end
            CLS_ABORT: begin
              acc_clear_s  = 1'b1;
              state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_ERROR;
          endcase
        end
        ST_ERROR: begin
          case (bus.rx_class)
            CLS_TERM: begin
              err_s        = 1'b1;
              acc_clear_s  = 1'b1;
              state_next_s = ST_IDLE;
            end
            CLS_ABORT: begin
              // Also empties the frame so digit_count reads 0 back in IDLE
              acc_clear_s  = 1'b1;
              state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_ERROR;
          endcase
        end
        default: begin
          acc_clear_s  = 1'b1;
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Overflow flag for the open frame
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      ovf_flag_r <= 1'b0;
    end else if (acc_clear_s) begin
      ovf_flag_r <= 1'b0;
    end else if (set_ovf_s) begin
      ovf_flag_r <= 1'b1;
    end else begin
      ovf_flag_r <= ovf_flag_r;
    end
  end

  // History registers and one-cycle status pulses
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      value_current_r <= '0;
      value_before_r  <= '0;
      frame_done_r    <= 1'b0;
      frame_ovf_r     <= 1'b0;
      frame_err_r     <= 1'b0;
    end else begin
      if (commit_s) begin
        value_before_r  <= value_current_r;
        value_current_r <= acc_s;
      end else begin
        value_before_r  <= value_before_r;
        value_current_r <= value_current_r;
      end
      frame_done_r <= commit_s;
      frame_ovf_r  <= commit_s & ovf_flag_r;
      frame_err_r  <= err_s;
    end
  end

  assign bus.value_current = value_current_r;
  assign bus.value_before  = value_before_r;
  assign bus.digit_count   = count_s;
  assign bus.frame_done    = frame_done_r;
  assign bus.frame_ovf     = frame_ovf_r;
  assign bus.frame_err     = frame_err_r;
  assign bus.busy          = (state_r != ST_IDLE);
endmodule
